control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on enter, legal range 2..3.
REQ-002 clock  in  1  single system clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; reset asserted when low.
REQ-004 IR75  in  3  opcode from datapath instruction register.
REQ-005 Aeq0  in  1  accumulator equals zero.
REQ-006 Apos  in  1  accumulator positive (non-zero, MSB clear).
REQ-007 enter  in  1  asynchronous user push-button; active high.
REQ-008 IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub  out  1 each  datapath control strobes.
REQ-009 Asel  out  2  accumulator source: 00 adder/subtractor, 01 Minput, 10 RAM data, 11 unused.
REQ-010 halt  out  1  high while in HALT state.
REQ-011 state_dbg  out  4  current state encoding.
REQ-012 instr_count  out  8  count of completed instructions.

Function
REQ-013 Opcodes SHALL be: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 INPUT, 101 JZ, 110 JPOS, 111 HALT.
REQ-014 States SHALL be START=0, FETCH=1, DECODE=2, LOAD=3, STORE=4, ADD=5, SUB=6, INPUT=7, JZ=8, JPOS=9, HALT=10; codes 11..15 SHALL go to START on the next edge.
REQ-015 Transitions: START->FETCH; FETCH->DECODE; DECODE->execute state selected by IR75; LOAD/STORE/ADD/SUB/JZ/JPOS->FETCH; INPUT->FETCH only on enter pulse, else stay; HALT->HALT until reset.
REQ-016 Outputs SHALL be Moore-decoded from state, except Aload in INPUT and PCload in JZ/JPOS; all strobes not listed below are 0 and Asel=00.
REQ-017 START: all strobes 0.
REQ-018 FETCH: IRload=1, PCload=1, JMPmux=0, Meminst=0.
REQ-019 DECODE: Meminst=1.
REQ-020 LOAD: Meminst=1, Asel=10, Aload=1.
REQ-021 STORE: Meminst=1, MemWr=1.
REQ-022 ADD: Meminst=1, Asel=00, Sub=0, Aload=1; SUB: same with Sub=1.
REQ-023 INPUT: Asel=01; Aload=1 only in the cycle the enter pulse is high.
REQ-024 JZ: JMPmux=1, PCload=Aeq0; JPOS: JMPmux=1, PCload=Apos.
REQ-025 HALT: all strobes 0, halt=1.
REQ-026 enter SHALL pass through SYNC_STAGES flops then a rising-edge detector; pulse is one cycle wide per low-to-high transition, visible SYNC_STAGES edges after enter rises.
REQ-027 Holding enter high SHALL yield exactly one pulse; a pulse outside INPUT SHALL be discarded.
REQ-028 Non-INPUT, non-HALT instructions SHALL take exactly 3 cycles (FETCH, DECODE, execute).
REQ-029 instr_count SHALL increment on every exit from an execute state to FETCH, wrapping 255->0; it SHALL not increment in HALT.

Reset
REQ-030 On reset low: state=START, synchronizer and edge flops 0, instr_count=0, all strobes 0, halt=0, state_dbg=0, immediately and regardless of clock.
REQ-031 Reset asserted mid-instruction (including during MemWr=1) SHALL abort it with no further strobes; first FETCH occurs on the second rising edge after reset deasserts.

Structure
REQ-032 Shared package ctrl_pkg SHALL hold the state encoding, opcode constants and Asel codes, also used by the datapath bench.
REQ-033 Sub-module edge_sync SHALL implement the synchronizer plus rising-edge detector with SYNC_STAGES parameter and the same clock/reset.

Verification
REQ-034 Reset release, IR75=000 -> START, FETCH (IRload=PCload=1), DECODE (Meminst=1), LOAD (Aload=1, Asel=10), FETCH; instr_count=1.
REQ-035 IR75=101 with Aeq0=0 -> JZ cycle JMPmux=1, PCload=0; repeat with Aeq0=1 -> PCload=1.
REQ-036 IR75=100, enter held high 20 cycles from cycle 5 of INPUT -> exactly one Aload=1 with Asel=01, then FETCH; count +1.
REQ-037 IR75=111 -> halt=1, state_dbg=10, strobes 0 for 50 cycles, instr_count unchanged.
REQ-038 Reset pulled low during STORE -> MemWr drops same cycle, state_dbg=0; after release, sequence restarts at START.
REQ-039 256 ADD instructions from reset -> instr_count wraps to 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the accumulator machine: FSM states, opcodes and
// accumulator source select codes (also used by the datapath bench).
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_STORE  = 4'd4,
    S_ADD    = 4'd5,
    S_SUB    = 4'd6,
    S_INPUT  = 4'd7,
    S_JZ     = 4'd8,
    S_JPOS   = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_RAM = 2'b10;

  // Execute states are laid out in opcode order starting at LOAD.
  function automatic state_t exec_state(input logic [2:0] op);
    return state_t'({1'b0, op} + 4'd3);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous level and emits a one-cycle pulse per rising edge.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/control_unit.sv
// Moore control FSM for the accumulator datapath, with a synchronized enter
// button and a completed-instruction counter.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] IR75,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       enter,
  output logic       IRload,
  output logic       JMPmux,
  output logic       PCload,
  output logic       Meminst,
  output logic       MemWr,
  output logic       Aload,
  output logic       Sub,
  output logic [1:0] Asel,
  output logic       halt,
  output logic [3:0] state_dbg,
  output logic [7:0] instr_count
);

  state_t state, next;
  logic   enter_pulse;
  logic   run_n;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_enter (
    .clock (clock),
    .reset (reset),
    .d     (enter),
    .pulse (enter_pulse)
  );

  // Reset asserts immediately but releases on a clock edge, so the FSM
  // leaves START one edge later and the first FETCH lands on the second edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) run_n <= 1'b0;
    else        run_n <= 1'b1;
  end

  always_ff @(posedge clock or negedge run_n) begin
    if (!run_n) state <= S_START;
    else        state <= next;
  end

  always_ff @(posedge clock or negedge run_n) begin
    if (!run_n)                                    instr_count <= '0;
    else if (next == S_FETCH && state != S_START)  instr_count <= instr_count + 8'd1;
  end

  always_comb begin
    next = S_START;
    case (state)
      S_START:  next = S_FETCH;
      S_FETCH:  next = S_DECODE;
      S_DECODE: next = exec_state(IR75);
      S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS: next = S_FETCH;
      S_INPUT:  next = enter_pulse ? S_FETCH : S_INPUT;
      S_HALT:   next = S_HALT;
      default:  next = S_START;
    endcase
  end

  always_comb begin
    IRload  = 1'b0;
    JMPmux  = 1'b0;
    PCload  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Asel    = ASEL_ALU;
    halt    = 1'b0;
    case (state)
      S_FETCH:  begin IRload = 1'b1; PCload = 1'b1; end
      S_DECODE: Meminst = 1'b1;
      S_LOAD:   begin Meminst = 1'b1; Asel = ASEL_RAM; Aload = 1'b1; end
      S_STORE:  begin Meminst = 1'b1; MemWr = 1'b1; end
      S_ADD:    begin Meminst = 1'b1; Aload = 1'b1; end
      S_SUB:    begin Meminst = 1'b1; Aload = 1'b1; Sub = 1'b1; end
      S_INPUT:  begin Asel = ASEL_IN; Aload = enter_pulse; end
      S_JZ:     begin JMPmux = 1'b1; PCload = Aeq0; end
      S_JPOS:   begin JMPmux = 1'b1; PCload = Apos; end
      S_HALT:   halt = 1'b1;
      default:  ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected output vectors are queued as
// stimulus is planned and compared one per clock as the DUT steps.
module tb_control_unit;

  logic       clock, reset;
  logic [2:0] IR75;
  logic       Aeq0, Apos, enter;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, halt;
  logic [1:0] Asel;
  logic [3:0] state_dbg;
  logic [7:0] instr_count;

  int checks = 0;
  int errors = 0;

  control_unit #(.SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .IR75(IR75), .Aeq0(Aeq0), .Apos(Apos),
    .enter(enter), .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload),
    .Meminst(Meminst), .MemWr(MemWr), .Aload(Aload), .Sub(Sub), .Asel(Asel),
    .halt(halt), .state_dbg(state_dbg), .instr_count(instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {state, IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, halt}
  localparam logic [14:0] V_START  = {4'd0,  7'b0000000, 2'b00, 1'b0};
  localparam logic [14:0] V_FETCH  = {4'd1,  7'b1010000, 2'b00, 1'b0};
  localparam logic [14:0] V_DECODE = {4'd2,  7'b0001000, 2'b00, 1'b0};
  localparam logic [14:0] V_LOAD   = {4'd3,  7'b0001010, 2'b10, 1'b0};
  localparam logic [14:0] V_STORE  = {4'd4,  7'b0001100, 2'b00, 1'b0};
  localparam logic [14:0] V_ADD    = {4'd5,  7'b0001010, 2'b00, 1'b0};
  localparam logic [14:0] V_SUB    = {4'd6,  7'b0001011, 2'b00, 1'b0};
  localparam logic [14:0] V_INIDLE = {4'd7,  7'b0000000, 2'b01, 1'b0};
  localparam logic [14:0] V_INLOAD = {4'd7,  7'b0000010, 2'b01, 1'b0};
  localparam logic [14:0] V_JZ0    = {4'd8,  7'b0100000, 2'b00, 1'b0};
  localparam logic [14:0] V_JZ1    = {4'd8,  7'b0110000, 2'b00, 1'b0};
  localparam logic [14:0] V_JP0    = {4'd9,  7'b0100000, 2'b00, 1'b0};
  localparam logic [14:0] V_JP1    = {4'd9,  7'b0110000, 2'b00, 1'b0};
  localparam logic [14:0] V_HALT   = {4'd10, 7'b0000000, 2'b00, 1'b1};

  typedef struct {
    logic [14:0] v;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];

  function automatic logic [14:0] obs();
    return {state_dbg, IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, halt};
  endfunction

  task automatic push(input logic [14:0] v, input logic [7:0] c);
    exp_t e;
    e.v = v;
    e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Asserts reset, then releases it 1ns after an edge; the next edge is edge 1.
  task automatic apply_reset();
    sb.delete();
    @(negedge clock);
    enter = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    @(negedge clock);
    IR75 = 3'b000;
    reset = 1'b0;
    #1;
    checks++;
    if (obs() !== V_START || instr_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_async: got %h/%0d exp %h/0", obs(), instr_count, V_START);
    end
    repeat (3) begin
      tick();
      checks++;
      if (obs() !== V_START || instr_count !== 8'd0) begin
        errors++;
        $display("FAIL reset_hold: got %h/%0d exp %h/0", obs(), instr_count, V_START);
      end
    end
    reset = 1'b1;
    push(V_START, 0);
    push(V_FETCH, 0);
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v || instr_count !== e.cnt) begin
        errors++;
        $display("FAIL reset_release: got %h/%0d exp %h/%0d", obs(), instr_count, e.v, e.cnt);
      end
    end
  endtask

  task automatic test_load();
    exp_t e;
    IR75 = 3'b000;
    apply_reset();
    push(V_START, 0); push(V_FETCH, 0); push(V_DECODE, 0); push(V_LOAD, 0); push(V_FETCH, 1);
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v || instr_count !== e.cnt) begin
        errors++;
        $display("FAIL load: got %h/%0d exp %h/%0d", obs(), instr_count, e.v, e.cnt);
      end
    end
  endtask

  task automatic test_jump();
    exp_t e;
    logic [14:0] vx;
    for (int k = 0; k < 4; k++) begin
      IR75 = (k < 2) ? 3'b101 : 3'b110;
      Aeq0 = (k < 2) ? k[0] : ~k[0];
      Apos = (k < 2) ? ~k[0] : k[0];
      case (k)
        0: vx = V_JZ0;
        1: vx = V_JZ1;
        2: vx = V_JP0;
        default: vx = V_JP1;
      endcase
      apply_reset();
      push(V_START, 0); push(V_FETCH, 0); push(V_DECODE, 0); push(vx, 0); push(V_FETCH, 1);
      while (sb.size() > 0) begin
        tick();
        e = sb.pop_front();
        checks++;
        if (obs() !== e.v || instr_count !== e.cnt) begin
          errors++;
          $display("FAIL jump%0d: got %h/%0d exp %h/%0d", k, obs(), instr_count, e.v, e.cnt);
        end
      end
    end
  endtask

  task automatic test_input();
    exp_t e;
    int n;
    IR75 = 3'b100;
    apply_reset();
    push(V_START, 0); push(V_FETCH, 0); push(V_DECODE, 0);
    repeat (5) push(V_INIDLE, 0);
    push(V_INLOAD, 0);
    push(V_FETCH, 1); push(V_DECODE, 1);
    repeat (19) push(V_INIDLE, 1);
    n = 0;
    while (sb.size() > 0) begin
      tick();
      n++;
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v || instr_count !== e.cnt) begin
        errors++;
        $display("FAIL input n=%0d: got %h/%0d exp %h/%0d", n, obs(), instr_count, e.v, e.cnt);
      end
      enter = (n >= 7 && n <= 26);
    end
    enter = 1'b0;
  endtask

  task automatic test_halt();
    exp_t e;
    IR75 = 3'b000;
    apply_reset();
    push(V_START, 0); push(V_FETCH, 0); push(V_DECODE, 0); push(V_LOAD, 0);
    push(V_FETCH, 1); push(V_DECODE, 1);
    repeat (50) push(V_HALT, 1);
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v || instr_count !== e.cnt) begin
        errors++;
        $display("FAIL halt: got %h/%0d exp %h/%0d", obs(), instr_count, e.v, e.cnt);
      end
      if (e.v == V_LOAD)      IR75 = 3'b111;
      else if (e.v == V_HALT) IR75 = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic test_store_reset();
    exp_t e;
    IR75 = 3'b001;
    apply_reset();
    push(V_START, 0); push(V_FETCH, 0); push(V_DECODE, 0); push(V_STORE, 0);
    push(V_FETCH, 1); push(V_DECODE, 1); push(V_STORE, 1);
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v || instr_count !== e.cnt) begin
        errors++;
        $display("FAIL store: got %h/%0d exp %h/%0d", obs(), instr_count, e.v, e.cnt);
      end
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs() !== V_START || instr_count !== 8'd0) begin
      errors++;
      $display("FAIL store_abort: got %h/%0d exp %h/0", obs(), instr_count, V_START);
    end
    tick();
    reset = 1'b1;
    push(V_START, 0); push(V_FETCH, 0); push(V_DECODE, 0); push(V_STORE, 0);
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v || instr_count !== e.cnt) begin
        errors++;
        $display("FAIL store_restart: got %h/%0d exp %h/%0d", obs(), instr_count, e.v, e.cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [2:0]  ops [6];
    logic [14:0] ex  [6];
    int k;
    ops[0] = 3'b000; ex[0] = V_LOAD;
    ops[1] = 3'b010; ex[1] = V_ADD;
    ops[2] = 3'b011; ex[2] = V_SUB;
    ops[3] = 3'b001; ex[3] = V_STORE;
    ops[4] = 3'b101; ex[4] = V_JZ1;
    ops[5] = 3'b110; ex[5] = V_JP0;
    Aeq0 = 1'b1;
    Apos = 1'b0;
    IR75 = 3'b000;
    apply_reset();
    push(V_START, 0);
    for (int i = 0; i < 6; i++) begin
      push(V_FETCH, 8'(i)); push(V_DECODE, 8'(i)); push(ex[i], 8'(i));
    end
    push(V_FETCH, 6);
    k = 0;
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v || instr_count !== e.cnt) begin
        errors++;
        $display("FAIL b2b op%0d: got %h/%0d exp %h/%0d", k, obs(), instr_count, e.v, e.cnt);
      end
      if (e.v == V_FETCH && k < 6) begin
        IR75 = ops[k];
        k++;
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    int n;
    IR75 = 3'b010;
    apply_reset();
    push(V_START, 0);
    for (int i = 0; i < 256; i++) begin
      push(V_FETCH, 8'(i)); push(V_DECODE, 8'(i)); push(V_ADD, 8'(i));
    end
    push(V_FETCH, 0);
    n = 0;
    while (sb.size() > 0) begin
      tick();
      n++;
      e = sb.pop_front();
      checks++;
      if (obs() !== e.v || instr_count !== e.cnt) begin
        errors++;
        $display("FAIL wrap n=%0d: got %h/%0d exp %h/%0d", n, obs(), instr_count, e.v, e.cnt);
      end
      // enter pulses outside INPUT must not disturb the sequence
      enter = ((n % 7) < 3);
    end
    enter = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    IR75  = 3'b000;
    Aeq0  = 1'b0;
    Apos  = 1'b0;
    enter = 1'b0;
    test_reset();
    test_load();
    test_jump();
    test_input();
    test_halt();
    test_store_reset();
    test_back_to_back();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
